half_life_decay_engine: RTL and testbench

Downstream consumer of the half-life up/down counter. Takes the 4-bit counter value as the half-life period selection and an initial quantity. On `start` it models radioactive decay: every half-life period the quantity is halved, until it reaches zero. It drives the display and status logic with the live quantity, a per-half-life event pulse and an elapsed half-life count.

---
 rtl/half_life_decay_engine.sv | 141 ++++++++++++++
 tb/tb_half_life_decay_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/half_life_decay_engine.sv
`default_nettype none
// ============================================================================
// Module   : half_life_decay_engine
// Purpose  : Models radioactive decay of a quantity. After start, the
//            quantity is halved once every (period+1) base ticks until it
//            reaches zero. Reports the live quantity, a one-cycle pulse per
//            halving, the number of half-lives elapsed, and busy/done status.
// Revision : 1.0 - initial release
// ============================================================================
module half_life_decay_engine #(
  parameter int TICK_DIV = 1000,  // clk cycles per base tick (>= 2)
  parameter int QW       = 8      // quantity width (2..15)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    period,
  input  logic [QW-1:0] init_qty,
  output logic [QW-1:0] qty,
  output logic [3:0]    halves,
  output logic          halflife_pulse,
  output logic          busy,
  output logic          done
);

  // Prescaler width; TICK_DIV >= 2 always gives at least one bit.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q,  state_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [3:0]    sub_q,    sub_d;
  logic [3:0]    period_q, period_d;
  logic [QW-1:0] qty_q,    qty_d;
  logic [3:0]    halves_q, halves_d;
  logic          pulse_q,  pulse_d;

  logic          tick_w;
  logic [QW-1:0] half_qty_w;

  // A base tick is the cycle in which the prescaler sits at its last count.
  always_comb begin
    tick_w     = (presc_q == C_TICK_LAST);
    half_qty_w = qty_q >> 1;
  end

  // Next-state logic: run acceptance, tick/sub-tick counting and halving.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sub_d    = sub_q;
    period_d = period_q;
    qty_d    = qty_q;
    halves_d = halves_q;
    pulse_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over abort here; abort has no meaning outside a run.
        if (start) begin
          halves_d = 4'd0;
          if (init_qty != '0) begin
            period_d = period;
            qty_d    = init_qty;
            presc_d  = '0;
            sub_d    = 4'd0;
            state_d  = S_RUN;
          end else begin
            qty_d    = '0;
            state_d  = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          // Freeze quantity and count; a coincident tick is discarded.
          state_d = S_IDLE;
        end else begin
          presc_d = tick_w ? '0 : presc_q + PW'(1);
          if (tick_w) begin
            if (sub_q == period_q) begin
              sub_d    = 4'd0;
              qty_d    = half_qty_w;
              halves_d = (halves_q == 4'd15) ? 4'd15 : halves_q + 4'd1;
              pulse_d  = 1'b1;
              if (half_qty_w == '0) begin
                state_d = S_DONE;
              end
            end else begin
              sub_d = sub_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      sub_q    <= 4'd0;
      period_q <= 4'd0;
      qty_q    <= '0;
      halves_q <= 4'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sub_q    <= sub_d;
      period_q <= period_d;
      qty_q    <= qty_d;
      halves_q <= halves_d;
      pulse_q  <= pulse_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    qty            = qty_q;
    halves         = halves_q;
    halflife_pulse = pulse_q;
    busy           = (state_q == S_RUN);
    done           = (state_q == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_half_life_decay_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_life_decay_engine
// Purpose  : Self-checking bench for half_life_decay_engine. A cycle-level
//            reference model derives halving times from elapsed cycles since
//            the accepted start, (period+1)*TICK_DIV per half-life.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_life_decay_engine;

  localparam int TD = 4;
  localparam int QW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [3:0]    period;
  logic [QW-1:0] init_qty;
  logic [QW-1:0] qty;
  logic [3:0]    halves;
  logic          halflife_pulse;
  logic          busy;
  logic          done;

  half_life_decay_engine #(.TICK_DIV(TD), .QW(QW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .period         (period),
    .init_qty       (init_qty),
    .qty            (qty),
    .halves         (halves),
    .halflife_pulse (halflife_pulse),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: 0 idle, 1 run, 2 done
  int     m_st     = 0;
  int     m_qty    = 0;
  int     m_halves = 0;
  int     m_p      = 0;
  int     m_pulse  = 0;
  longint ecount   = 0;
  longint m_t0     = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] p;
    int         exp_h;
    int         exp_cyc;
  } run_t;

  run_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    ecount++;
    if (reset) begin
      m_st = 0; m_qty = 0; m_halves = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_st == 1) begin
        if (abort) begin
          m_st = 0;
        end else if (((ecount - m_t0) % ((m_p + 1) * TD)) == 0) begin
          m_qty    = m_qty / 2;
          m_halves = (m_halves < 15) ? m_halves + 1 : 15;
          m_pulse  = 1;
          if (m_qty == 0) m_st = 2;
        end
      end else if (start) begin
        m_halves = 0;
        if (init_qty != 0) begin
          m_st = 1; m_qty = int'(init_qty); m_p = int'(period); m_t0 = ecount;
        end else begin
          m_st = 2; m_qty = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("qty", qty, m_qty);
    chk("halves", halves, m_halves);
    chk("pulse", halflife_pulse, m_pulse);
    chk("busy", busy, (m_st == 1));
    chk("done", done, (m_st == 2));
    if (halflife_pulse === 1'b1) pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_start(input logic [7:0] q, input logic [3:0] p);
    init_qty = q; period = p; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    tbl[0] = '{8'h80, 4'd1, 8, 64};
    tbl[1] = '{8'h01, 4'd0, 1, 4};
    tbl[2] = '{8'hFF, 4'd15, 8, 512};
    tbl[3] = '{8'h05, 4'd2, 3, 36};
    tbl[4] = '{8'h00, 4'd3, 0, 0};
    tbl[5] = '{8'h0F, 4'd0, 4, 16};

    // Reset held for 3 cycles with random inputs
    reset = 1'b1; start = 1'b0; abort = 1'b0; period = 4'd0; init_qty = '0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); abort = 1'($urandom);
      period = 4'($urandom); init_qty = 8'($urandom);
      step();
    end
    chk("reset_qty", qty, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    steps(3);
    chk("idle_qty", qty, 0);
    chk("idle_done", done, 0);

    // Table-driven full runs
    for (int t = 0; t < 6; t++) begin
      do_start(tbl[t].q, tbl[t].p);
      init_qty = 8'($urandom); period = 4'($urandom);
      pulses = 0;
      wait_done(cnt);
      step();
      chk("run_cycles", cnt, tbl[t].exp_cyc);
      chk("run_halves", halves, tbl[t].exp_h);
      chk("run_qty", qty, 0);
      chk("run_pulses", pulses, tbl[t].exp_h);
    end

    // Abort on a tick cycle after two halvings
    do_start(8'hC8, 4'd0);
    steps(8);
    chk("abort_pre_qty", qty, 8'h32);
    chk("abort_pre_halves", halves, 2);
    steps(3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_qty", qty, 8'h32);
    chk("abort_halves", halves, 2);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_pulse", halflife_pulse, 0);
    abort = 1'b1;
    steps(2);
    abort = 1'b0;
    chk("abort_idle_qty", qty, 8'h32);

    // Ignored period/start changes during RUN, then reset at halving 3
    do_start(8'h10, 4'd3);
    steps(5);
    period = 4'd0; init_qty = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    steps(9);
    chk("ign_qty15", qty, 8'h10);
    step();
    chk("ign_qty16", qty, 8'h08);
    steps(15);
    chk("ign_qty31", qty, 8'h08);
    step();
    chk("ign_qty32", qty, 8'h04);
    steps(15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_qty", qty, 0);
    chk("midreset_halves", halves, 0);
    chk("midreset_pulse", halflife_pulse, 0);
    chk("midreset_busy", busy, 0);
    step();
    chk("midreset_pulse2", halflife_pulse, 0);

    // Restart from DONE with no dead cycles
    do_start(8'h03, 4'd0);
    wait_done(cnt);
    chk("pre_restart_done", done, 1);
    do_start(8'h05, 4'd1);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_qty", qty, 8'h05);
    chk("restart_halves", halves, 0);
    wait_done(cnt);
    chk("restart_cycles", cnt, 24);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      period   = 4'($urandom_range(0, 3));
      init_qty = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
